// File: rtl/spi_adc_scan_sequencer_pkg.sv
// Shared types and helpers for the SPI ADC scan sequencer.
package spi_scan_pkg;
  localparam int          CH_W       = 4;
  localparam int          SAMPLE_W   = 12;
  localparam logic [3:0]  CMD_PREFIX = 4'h1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_LAUNCH,
    S_WAIT,
    S_STORE,
    S_GAP
  } state_t;

  // ADC command word: prefix, channel, padding.
  function automatic logic [15:0] build_cmd(input logic [CH_W-1:0] ch);
    return {CMD_PREFIX, ch, 8'h00};
  endfunction
endpackage

// File: rtl/spi_adc_scan_sequencer_if.sv
// SPI master side and result port of the scan sequencer.
interface spi_adc_scan_sequencer_if;
  import spi_scan_pkg::*;

  logic                spi_start;
  logic [15:0]         spi_cmd_data;
  logic [1:0]          spi_freq_control;
  logic                spi_rx_valid;
  logic [15:0]         spi_miso_data;
  logic                result_valid;
  logic                result_ready;
  logic [CH_W-1:0]     result_ch;
  logic [SAMPLE_W-1:0] result_data;

  modport master (
    output spi_start, spi_cmd_data, spi_freq_control,
    output result_valid, result_ch, result_data,
    input  spi_rx_valid, spi_miso_data, result_ready
  );

  modport slave (
    input  spi_start, spi_cmd_data, spi_freq_control,
    input  result_valid, result_ch, result_data,
    output spi_rx_valid, spi_miso_data, result_ready
  );
endinterface

// File: rtl/spi_adc_scan_sequencer_scan_next_ch.sv
// Picks the first set mask bit at or after ptr, wrapping at NUM_CH.
module scan_next_ch
  import spi_scan_pkg::*;
#(
  parameter int NUM_CH = 8
) (
  input  logic [15:0]     mask,
  input  logic [CH_W-1:0] ptr,
  output logic            found,
  output logic [CH_W-1:0] ch
);
  logic [4:0] idx;

  // Walk offsets from far to near so the nearest set bit is assigned last and wins.
  always_comb begin
    found = 1'b0;
    ch    = '0;
    idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + 5'(i);
      if (idx >= 5'(NUM_CH)) idx = idx - 5'(NUM_CH);
      if (mask[idx[3:0]]) begin
        found = 1'b1;
        ch    = idx[3:0];
      end
    end
  end
endmodule

// File: rtl/spi_adc_scan_sequencer.sv
// Round-robin ADC channel scanner driving an SPI master and presenting
// {channel, sample} results on a valid/ready port.
module spi_adc_scan_sequencer
  import spi_scan_pkg::*;
#(
  parameter int NUM_CH     = 8,
  parameter int GAP_CYCLES = 500,
  parameter int TIMEOUT    = 4096
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [15:0]                   ch_mask,
  input  logic [1:0]                    freq_sel,
  input  logic                          clr_err,
  spi_adc_scan_sequencer_if.master      bus,
  output logic                          busy,
  output logic                          err_timeout,
  output logic                          err_echo,
  output logic                          err_overrun
);
  localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ptr_q, sel_ch_q, ch_q;
  logic [15:0]         cmd_q, rx_q;
  logic [1:0]          freq_q;
  logic                start_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                rvalid_q;
  logic [CH_W-1:0]     rch_q;
  logic [SAMPLE_W-1:0] rdata_q;

  logic [15:0]         valid_mask, mask_eff;
  logic                nxt_found;
  logic [CH_W-1:0]     nxt_ch;
  logic                timeout_hit, gap_done, echo_bad, store_load, store_drop;

  // Mask bits beyond the configured channel count never participate.
  always_comb begin
    valid_mask = '0;
    for (int i = 0; i < 16; i++) valid_mask[i] = (i < NUM_CH);
  end
  assign mask_eff = ch_mask & valid_mask;

  scan_next_ch #(.NUM_CH(NUM_CH)) u_next (
    .mask  (mask_eff),
    .ptr   (ptr_q),
    .found (nxt_found),
    .ch    (nxt_ch)
  );

  // A reply arriving on the last allowed cycle still counts as a reply.
  assign timeout_hit = (state_q == S_WAIT) && !bus.spi_rx_valid &&
                       (cnt_q == CNT_W'(TIMEOUT - 1));
  assign gap_done    = (state_q == S_GAP) && (cnt_q == CNT_W'(GAP_CYCLES - 1));
  assign echo_bad    = (state_q == S_STORE) && (rx_q[15:12] != ch_q);
  assign store_load  = (state_q == S_STORE) && (!rvalid_q || bus.result_ready);
  assign store_drop  = (state_q == S_STORE) && rvalid_q && !bus.result_ready;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (enable && (mask_eff != '0)) state_d = S_SELECT;
      S_SELECT: state_d = nxt_found ? S_LAUNCH : S_IDLE;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT:   if (bus.spi_rx_valid) state_d = S_STORE;
                else if (timeout_hit) state_d = S_GAP;
      S_STORE:  state_d = S_GAP;
      S_GAP:    if (gap_done) state_d = enable ? S_SELECT : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Frame datapath: channel pick, command/frequency latch, shared cycle counter.
  // start is registered so it appears together with the freshly latched command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q    <= '0;
      sel_ch_q <= '0;
      ch_q     <= '0;
      cmd_q    <= '0;
      freq_q   <= '0;
      start_q  <= 1'b0;
      cnt_q    <= '0;
      rx_q     <= '0;
    end else begin
      start_q <= (state_q == S_LAUNCH);
      case (state_q)
        S_SELECT: sel_ch_q <= nxt_ch;
        S_LAUNCH: begin
          ch_q   <= sel_ch_q;
          cmd_q  <= build_cmd(sel_ch_q);
          freq_q <= freq_sel;
          cnt_q  <= '0;
        end
        S_WAIT: begin
          if (bus.spi_rx_valid) begin
            rx_q  <= bus.spi_miso_data;
            cnt_q <= '0;
          end else if (timeout_hit) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_STORE: begin
          ptr_q <= (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
          cnt_q <= '0;
        end
        S_GAP:   cnt_q <= cnt_q + 1'b1;
        default: ;
      endcase
    end
  end

  // Result register: loads on STORE when free or draining, else holds old data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      rch_q    <= '0;
      rdata_q  <= '0;
    end else if (store_load) begin
      rvalid_q <= 1'b1;
      rch_q    <= ch_q;
      rdata_q  <= rx_q[SAMPLE_W-1:0];
    end else if (rvalid_q && bus.result_ready) begin
      rvalid_q <= 1'b0;
    end
  end

  // Sticky error flags; a new event beats a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_timeout <= 1'b0;
      err_echo    <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_timeout <= timeout_hit | (err_timeout & ~clr_err);
      err_echo    <= echo_bad    | (err_echo    & ~clr_err);
      err_overrun <= store_drop  | (err_overrun & ~clr_err);
    end
  end

  assign busy                 = (state_q != S_IDLE);
  assign bus.spi_start        = start_q;
  assign bus.spi_cmd_data     = cmd_q;
  assign bus.spi_freq_control = freq_q;
  assign bus.result_valid     = rvalid_q;
  assign bus.result_ch        = rch_q;
  assign bus.result_data      = rdata_q;
endmodule

// File: tb/tb_spi_adc_scan_sequencer.sv
// Directed bench for the scan sequencer with a behavioural SPI master + ADC reply model.
module tb_spi_adc_scan_sequencer;
  localparam int NUM_CH     = 8;
  localparam int GAP_CYCLES = 8;
  localparam int TIMEOUT    = 64;
  localparam int ADC_LAT    = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] ch_mask;
  logic [1:0]  freq_sel;
  logic        clr_err;
  logic        busy, err_timeout, err_echo, err_overrun;

  spi_adc_scan_sequencer_if bus();

  spi_adc_scan_sequencer #(
    .NUM_CH(NUM_CH), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .ch_mask     (ch_mask),
    .freq_sel    (freq_sel),
    .clr_err     (clr_err),
    .bus         (bus),
    .busy        (busy),
    .err_timeout (err_timeout),
    .err_echo    (err_echo),
    .err_overrun (err_overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int start_cnt = 0;
  int rx_cyc = 0;
  int epoch  = 0;
  bit adc_silent = 1'b0;
  logic [3:0] echo_off = 4'd0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.spi_start === 1'b1) start_cnt <= start_cnt + 1;

  // ADC reply model: answers each start after ADC_LAT cycles unless silent or reset since.
  initial begin
    int e;
    logic [3:0] c;
    bus.spi_rx_valid  = 1'b0;
    bus.spi_miso_data = 16'h0000;
    forever begin
      @(negedge clk);
      if (bus.spi_start === 1'b1) begin
        e = epoch;
        c = bus.spi_cmd_data[11:8];
        repeat (ADC_LAT) @(negedge clk);
        if (!adc_silent && e == epoch && !reset) begin
          bus.spi_miso_data = {c + echo_off, 12'hABC};
          bus.spi_rx_valid  = 1'b1;
          rx_cyc            = cyc;
          @(negedge clk);
          bus.spi_rx_valid  = 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // sel: 0 start, 1 result_valid, 2 idle, 3 err_timeout, 4 err_overrun
  task automatic wait_cond(input int sel, input int max, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < max && !hit; i++) begin
      @(negedge clk);
      case (sel)
        0: hit = (bus.spi_start === 1'b1);
        1: hit = (bus.result_valid === 1'b1);
        2: hit = (busy === 1'b0);
        3: hit = (err_timeout === 1'b1);
        default: hit = (err_overrun === 1'b1);
      endcase
    end
    check({tag, "_reached"}, {31'd0, hit}, 32'd1);
  endtask

  task automatic handshake();
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    epoch++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int s, n0;
    bit busy_seen, rv_seen;
    reset = 1'b1; enable = 1'b0; ch_mask = 16'h0; freq_sel = 2'd0; clr_err = 1'b0;
    bus.result_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_start",  {31'd0, bus.spi_start}, 32'd0);
    check("rst_cmd",    {16'd0, bus.spi_cmd_data}, 32'd0);
    check("rst_freq",   {30'd0, bus.spi_freq_control}, 32'd0);
    check("rst_rvalid", {31'd0, bus.result_valid}, 32'd0);
    check("rst_errs",   {29'd0, err_timeout, err_echo, err_overrun}, 32'd0);
    reset = 1'b0;

    // Normal scan of channels 0 and 2
    ch_mask = 16'h0005; freq_sel = 2'd2; enable = 1'b1;
    wait_cond(0, 100, "start0");
    check("f0_cmd",  {16'd0, bus.spi_cmd_data}, 32'h1000);
    check("f0_freq", {30'd0, bus.spi_freq_control}, 32'd2);
    check("f0_busy", {31'd0, busy}, 32'd1);
    freq_sel = 2'd1;
    @(negedge clk);
    check("f0_freq_hold", {30'd0, bus.spi_freq_control}, 32'd2);
    wait_cond(1, 100, "res0");
    check("r0_ch",   {28'd0, bus.result_ch}, 32'd0);
    check("r0_data", {20'd0, bus.result_data}, 32'hABC);
    check("r0_lat",  cyc - rx_cyc, 32'd2);
    handshake();
    check("r0_clear", {31'd0, bus.result_valid}, 32'd0);
    wait_cond(0, 100, "start1");
    check("f1_cmd",  {16'd0, bus.spi_cmd_data}, 32'h1200);
    check("f1_freq", {30'd0, bus.spi_freq_control}, 32'd1);
    wait_cond(1, 100, "res1");
    check("r1_ch",   {28'd0, bus.result_ch}, 32'd2);
    check("r1_data", {20'd0, bus.result_data}, 32'hABC);
    handshake();
    wait_cond(1, 100, "res2");
    check("r2_ch",   {28'd0, bus.result_ch}, 32'd0);
    check("r2_cmd",  {16'd0, bus.spi_cmd_data}, 32'h1000);
    handshake();
    check("scan_errs", {29'd0, err_timeout, err_echo, err_overrun}, 32'd0);

    // Empty mask: no frames, never busy
    ch_mask = 16'h0000; bus.result_ready = 1'b1;
    wait_cond(2, 200, "mask0_idle");
    n0 = start_cnt; busy_seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    check("mask0_starts", start_cnt, n0);
    check("mask0_busy", {31'd0, busy_seen}, 32'd0);
    bus.result_ready = 1'b0;

    // Silent ADC: timeout 64 cycles after start, scanning continues, no result
    adc_silent = 1'b1; ch_mask = 16'h0002;
    wait_cond(0, 100, "to_start");
    s = cyc;
    check("to_cmd", {16'd0, bus.spi_cmd_data}, 32'h1100);
    wait_cond(3, 200, "to_flag");
    check("to_delay", cyc - s, 32'd64);
    wait_cond(0, 100, "to_restart");
    rv_seen = bus.result_valid;
    check("to_no_result", {31'd0, rv_seen}, 32'd0);
    enable = 1'b0;
    wait_cond(2, 200, "to_idle");
    pulse_clr();
    check("to_clr", {31'd0, err_timeout}, 32'd0);
    adc_silent = 1'b0;

    // Overrun: consumer stalled across two completed frames
    do_reset();
    ch_mask = 16'h0005; enable = 1'b1;
    wait_cond(1, 100, "ov_res");
    check("ov_first_ch", {28'd0, bus.result_ch}, 32'd0);
    wait_cond(4, 200, "ov_flag");
    check("ov_hold_ch",   {28'd0, bus.result_ch}, 32'd0);
    check("ov_hold_data", {20'd0, bus.result_data}, 32'hABC);
    enable = 1'b0;
    wait_cond(2, 200, "ov_idle");
    check("ov_hold_ch2", {28'd0, bus.result_ch}, 32'd0);
    pulse_clr();
    check("ov_clr", {31'd0, err_overrun}, 32'd0);
    handshake();
    check("ov_drain", {31'd0, bus.result_valid}, 32'd0);

    // Bad echo: flag set, result tagged with commanded channel
    echo_off = 4'd1; ch_mask = 16'h0008; enable = 1'b1;
    wait_cond(1, 100, "echo_res");
    check("echo_ch",   {28'd0, bus.result_ch}, 32'd3);
    check("echo_data", {20'd0, bus.result_data}, 32'hABC);
    check("echo_flag", {31'd0, err_echo}, 32'd1);
    enable = 1'b0; bus.result_ready = 1'b1;
    wait_cond(2, 200, "echo_idle");
    bus.result_ready = 1'b0; echo_off = 4'd0;
    pulse_clr();
    check("echo_clr", {31'd0, err_echo}, 32'd0);

    // Reset during WAIT, then restart from channel 0
    ch_mask = 16'h0010; enable = 1'b1;
    wait_cond(0, 100, "rw_start");
    check("rw_cmd", {16'd0, bus.spi_cmd_data}, 32'h1400);
    repeat (3) @(negedge clk);
    reset = 1'b1; epoch++;
    #1;
    check("rw_busy",  {31'd0, busy}, 32'd0);
    check("rw_cmd0",  {16'd0, bus.spi_cmd_data}, 32'd0);
    check("rw_freq0", {30'd0, bus.spi_freq_control}, 32'd0);
    check("rw_outs",  {28'd0, bus.spi_start, bus.result_valid, err_timeout, err_overrun}, 32'd0);
    ch_mask = 16'h0011;
    @(negedge clk);
    reset = 1'b0;
    wait_cond(0, 100, "rw_restart");
    check("rw_first_ch0", {16'd0, bus.spi_cmd_data}, 32'h1000);
    enable = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
